// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT bus front-end.
// Holds the default register addresses, the controller state encoding and
// the byte-strobe to bit-mask helper used by the read-modify-write path.
package clint_pkg;

    // Default byte addresses of the timer registers.
    localparam logic [63:0] CLINT_ADDR_MTIME    = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] CLINT_ADDR_MTIMECMP = 64'h0000_0000_0200_4000;

    localparam logic [7:0] STRB_FULL = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StRsp
    } state_e;

    // Expand each strobe bit into a full byte of mask bits.
    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/clint_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   req_i[1:0]   request valids of port 1 / port 0
//   accept_i     the granted request was accepted this cycle
//   gnt_o[1:0]   one-hot grant
// On a tie the port that was not served last wins. rr_last resets to 1 so
// port 0 wins the first tie.
module clint_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic rr_last_q;
    logic rr_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = rr_last_q ? 2'b01 : 2'b10;
        end else if (req_i[0]) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end else begin
            // Idle: point at the port that would win the next tie.
            gnt_o = rr_last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (accept_i) begin
            rr_last_d = gnt_o[1];
        end
    end

endmodule

// File: rtl/clint_bus_ctrl.sv
// Bus front-end for the CLINT timer register block.
// Arbitrates the MEM-stage port (0) and the debug/host port (1) onto the
// timer's single register port, decodes and checks each access, and turns
// byte-strobed stores into a read-modify-write.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_reqN_* / o_reqN_ready         request channel of port N (valid/ready)
//   o_rspN_* / i_rspN_ready         response channel of port N (valid/ready)
//   o_tmr_wen/addr/wdata            timer register write/address/data
//   i_tmr_rdata                     timer read data, combinational from addr
module clint_bus_ctrl
    import clint_pkg::*;
#(
    parameter logic [63:0] ADDR_MTIME    = CLINT_ADDR_MTIME,
    parameter logic [63:0] ADDR_MTIMECMP = CLINT_ADDR_MTIMECMP
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [63:0] i_req0_addr,
    input  logic        i_req0_wen,
    input  logic [63:0] i_req0_wdata,
    input  logic [7:0]  i_req0_wstrb,
    output logic        o_rsp0_valid,
    input  logic        i_rsp0_ready,
    output logic [63:0] o_rsp0_rdata,
    output logic        o_rsp0_err,

    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [63:0] i_req1_addr,
    input  logic        i_req1_wen,
    input  logic [63:0] i_req1_wdata,
    input  logic [7:0]  i_req1_wstrb,
    output logic        o_rsp1_valid,
    input  logic        i_rsp1_ready,
    output logic [63:0] o_rsp1_rdata,
    output logic        o_rsp1_err,

    output logic        o_tmr_wen,
    output logic [63:0] o_tmr_addr,
    output logic [63:0] o_tmr_wdata,
    input  logic [63:0] i_tmr_rdata
);

    state_e      state_q, state_d;
    logic [63:0] addr_q,  addr_d;
    logic        wen_q,   wen_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        port_q,  port_d;
    logic [63:0] data_q,  data_d;
    logic        err_q,   err_d;

    logic [1:0]  gnt;
    logic        accept;
    logic        sel_port;
    logic [63:0] sel_addr;
    logic        sel_wen;
    logic [63:0] sel_wdata;
    logic [7:0]  sel_wstrb;
    logic        sel_dec_err;
    logic        rsp_ready_sel;
    logic [63:0] wr_mask;
    logic [63:0] wr_merged;
    logic [63:0] rsp_rdata;

    // ------------------------------------------------------------------
    // Arbitration and request selection
    // ------------------------------------------------------------------
    clint_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({i_req1_valid, i_req0_valid}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign o_req0_ready = (state_q == StIdle) && gnt[0];
    assign o_req1_ready = (state_q == StIdle) && gnt[1];
    assign accept       = (i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready);

    assign sel_port  = gnt[1];
    assign sel_addr  = sel_port ? i_req1_addr  : i_req0_addr;
    assign sel_wen   = sel_port ? i_req1_wen   : i_req0_wen;
    assign sel_wdata = sel_port ? i_req1_wdata : i_req0_wdata;
    assign sel_wstrb = sel_port ? i_req1_wstrb : i_req0_wstrb;

    assign sel_dec_err = ((sel_addr != ADDR_MTIME) && (sel_addr != ADDR_MTIMECMP)) ||
                         (sel_addr[2:0] != 3'b000);

    assign rsp_ready_sel = port_q ? i_rsp1_ready : i_rsp0_ready;

    // Full writes leave data_q at zero, so the merge degenerates to wdata.
    assign wr_mask   = strb_to_mask(wstrb_q);
    assign wr_merged = (data_q & ~wr_mask) | (wdata_q & wr_mask);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            port_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            port_q  <= port_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        port_d  = port_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = sel_addr;
                    wen_d   = sel_wen;
                    wdata_d = sel_wdata;
                    wstrb_d = sel_wstrb;
                    port_d  = sel_port;
                    data_d  = '0;
                    err_d   = sel_dec_err;
                    if (sel_dec_err) begin
                        state_d = StRsp;
                    end else if (!sel_wen) begin
                        state_d = StRd;
                    end else if (sel_wstrb == 8'h00) begin
                        // Empty store: acknowledge without touching the timer.
                        state_d = StRsp;
                    end else if (sel_wstrb == STRB_FULL) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                data_d  = i_tmr_rdata;
                state_d = wen_q ? StWr : StRsp;
            end
            StWr: begin
                state_d = StRsp;
            end
            StRsp: begin
                if (rsp_ready_sel) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_tmr_wen    = 1'b0;
        o_tmr_addr   = '0;
        o_tmr_wdata  = '0;
        o_rsp0_valid = 1'b0;
        o_rsp1_valid = 1'b0;
        o_rsp0_rdata = '0;
        o_rsp1_rdata = '0;
        o_rsp0_err   = 1'b0;
        o_rsp1_err   = 1'b0;
        // Writes return zero read data; data_q then holds the RMW old value.
        rsp_rdata    = wen_q ? 64'h0 : data_q;

        unique case (state_q)
            StRd: begin
                o_tmr_addr = addr_q;
            end
            StWr: begin
                o_tmr_wen   = 1'b1;
                o_tmr_addr  = addr_q;
                o_tmr_wdata = wr_merged;
            end
            StRsp: begin
                if (port_q) begin
                    o_rsp1_valid = 1'b1;
                    o_rsp1_rdata = rsp_rdata;
                    o_rsp1_err   = err_q;
                end else begin
                    o_rsp0_valid = 1'b1;
                    o_rsp0_rdata = rsp_rdata;
                    o_rsp0_err   = err_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_clint_bus_ctrl.sv
// Directed bench for clint_bus_ctrl with a two-register timer model.
module tb_clint_bus_ctrl;

    localparam logic [63:0] A_MT    = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;
    localparam logic [63:0] MT_INIT = 64'hDEAD_BEEF_0000_0042;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        r0_valid, r0_ready, r0_wen, rs0_valid, rs0_ready, rs0_err;
    logic [63:0] r0_addr, r0_wdata, rs0_rdata;
    logic [7:0]  r0_wstrb;
    logic        r1_valid, r1_ready, r1_wen, rs1_valid, rs1_ready, rs1_err;
    logic [63:0] r1_addr, r1_wdata, rs1_rdata;
    logic [7:0]  r1_wstrb;

    logic        tmr_wen;
    logic [63:0] tmr_addr, tmr_wdata, tmr_rdata;

    logic [63:0] m_time  = MT_INIT;
    logic [63:0] m_cmp   = 64'h0;
    int          wen_cnt = 0;
    int          wen_base;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clint_bus_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req0_valid (r0_valid),
        .o_req0_ready (r0_ready),
        .i_req0_addr  (r0_addr),
        .i_req0_wen   (r0_wen),
        .i_req0_wdata (r0_wdata),
        .i_req0_wstrb (r0_wstrb),
        .o_rsp0_valid (rs0_valid),
        .i_rsp0_ready (rs0_ready),
        .o_rsp0_rdata (rs0_rdata),
        .o_rsp0_err   (rs0_err),
        .i_req1_valid (r1_valid),
        .o_req1_ready (r1_ready),
        .i_req1_addr  (r1_addr),
        .i_req1_wen   (r1_wen),
        .i_req1_wdata (r1_wdata),
        .i_req1_wstrb (r1_wstrb),
        .o_rsp1_valid (rs1_valid),
        .i_rsp1_ready (rs1_ready),
        .o_rsp1_rdata (rs1_rdata),
        .o_rsp1_err   (rs1_err),
        .o_tmr_wen    (tmr_wen),
        .o_tmr_addr   (tmr_addr),
        .o_tmr_wdata  (tmr_wdata),
        .i_tmr_rdata  (tmr_rdata)
    );

    // Timer model: combinational read, write on the clock edge.
    always_comb begin
        if (tmr_addr == A_MT) begin
            tmr_rdata = m_time;
        end else if (tmr_addr == A_CMP) begin
            tmr_rdata = m_cmp;
        end else begin
            tmr_rdata = 64'h0;
        end
    end

    always @(posedge clk) begin
        if (tmr_wen) begin
            wen_cnt <= wen_cnt + 1;
            if (tmr_addr == A_MT) begin
                m_time <= tmr_wdata;
            end else if (tmr_addr == A_CMP) begin
                m_cmp <= tmr_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request in an IDLE cycle, expect immediate grant, return at T+1.
    task automatic issue(input int p, input logic [63:0] a, input logic w,
                         input logic [63:0] d, input logic [7:0] s);
        if (p == 0) begin
            r0_addr = a; r0_wen = w; r0_wdata = d; r0_wstrb = s; r0_valid = 1'b1;
        end else begin
            r1_addr = a; r1_wen = w; r1_wdata = d; r1_wstrb = s; r1_valid = 1'b1;
        end
        #1;
        if (p == 0) chk("req0_ready", 64'(r0_ready), 64'd1);
        else        chk("req1_ready", 64'(r1_ready), 64'd1);
        cyc();
        if (p == 0) r0_valid = 1'b0;
        else        r1_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        r0_valid = 1'b0; r0_addr = '0; r0_wen = 1'b0; r0_wdata = '0; r0_wstrb = '0;
        r1_valid = 1'b0; r1_addr = '0; r1_wen = 1'b0; r1_wdata = '0; r1_wstrb = '0;
        rs0_ready = 1'b1;
        rs1_ready = 1'b1;

        // Reset values
        repeat (2) cyc();
        chk("rst_rsp0_valid", 64'(rs0_valid), 64'd0);
        chk("rst_rsp1_valid", 64'(rs1_valid), 64'd0);
        chk("rst_rsp0_rdata", rs0_rdata, 64'd0);
        chk("rst_rsp0_err",   64'(rs0_err), 64'd0);
        chk("rst_tmr_wen",    64'(tmr_wen), 64'd0);
        chk("rst_tmr_addr",   tmr_addr, 64'd0);
        chk("rst_tmr_wdata",  tmr_wdata, 64'd0);
        #2 rst_n = 1'b1;
        cyc();

        // Port 0 full write to mtimecmp
        issue(0, A_CMP, 1'b1, 64'h1234, 8'hFF);
        chk("fw_wen_t1",   64'(tmr_wen), 64'd1);
        chk("fw_addr_t1",  tmr_addr, A_CMP);
        chk("fw_wdata_t1", tmr_wdata, 64'h1234);
        chk("fw_rsp_t1",   64'(rs0_valid), 64'd0);
        cyc();
        chk("fw_rsp_t2",   64'(rs0_valid), 64'd1);
        chk("fw_err_t2",   64'(rs0_err), 64'd0);
        chk("fw_wen_t2",   64'(tmr_wen), 64'd0);
        cyc();
        chk("fw_idle_rsp", 64'(rs0_valid), 64'd0);

        // Read back on port 0
        issue(0, A_CMP, 1'b0, 64'h0, 8'h00);
        chk("rd_addr_t1", tmr_addr, A_CMP);
        chk("rd_wen_t1",  64'(tmr_wen), 64'd0);
        cyc();
        chk("rd_rsp_t2",   64'(rs0_valid), 64'd1);
        chk("rd_rdata_t2", rs0_rdata, 64'h1234);
        cyc();

        // Port 1: set mtimecmp, then byte-0 partial write
        issue(1, A_CMP, 1'b1, 64'h1111_2222, 8'hFF);
        cyc();
        chk("p1fw_rsp", 64'(rs1_valid), 64'd1);
        cyc();
        issue(1, A_CMP, 1'b1, 64'hAB, 8'h01);
        chk("pw_wen_t1",   64'(tmr_wen), 64'd0);
        chk("pw_addr_t1",  tmr_addr, A_CMP);
        cyc();
        chk("pw_wen_t2",   64'(tmr_wen), 64'd1);
        chk("pw_wdata_t2", tmr_wdata, 64'h1111_22AB);
        chk("pw_rsp_t2",   64'(rs1_valid), 64'd0);
        cyc();
        chk("pw_rsp1_t3",  64'(rs1_valid), 64'd1);
        chk("pw_err_t3",   64'(rs1_err), 64'd0);
        chk("pw_rsp0_t3",  64'(rs0_valid), 64'd0);
        cyc();
        issue(1, A_CMP, 1'b0, 64'h0, 8'h00);
        cyc();
        chk("pw_readback", rs1_rdata, 64'h1111_22AB);
        cyc();

        // Both ports contend continuously; last served was port 1
        r0_addr = A_MT;  r0_wen = 1'b0; r0_wstrb = 8'h00; r0_valid = 1'b1;
        r1_addr = A_CMP; r1_wen = 1'b0; r1_wstrb = 8'h00; r1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (i % 2 == 0) begin
                chk("rr_ready_win",  64'(r0_ready), 64'd1);
                chk("rr_ready_lose", 64'(r1_ready), 64'd0);
            end else begin
                chk("rr_ready_win",  64'(r1_ready), 64'd1);
                chk("rr_ready_lose", 64'(r0_ready), 64'd0);
            end
            cyc();
            cyc();
            if (i % 2 == 0) begin
                chk("rr_rsp_own",   64'(rs0_valid), 64'd1);
                chk("rr_rdata",     rs0_rdata, MT_INIT);
                chk("rr_rsp_other", 64'(rs1_valid), 64'd0);
            end else begin
                chk("rr_rsp_own",   64'(rs1_valid), 64'd1);
                chk("rr_rdata",     rs1_rdata, 64'h1111_22AB);
                chk("rr_rsp_other", 64'(rs0_valid), 64'd0);
            end
            cyc();
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        // Decode errors and empty store: no timer write
        wen_base = wen_cnt;
        issue(0, 64'h0200_4004, 1'b0, 64'h0, 8'h00);
        chk("misal_rsp",   64'(rs0_valid), 64'd1);
        chk("misal_err",   64'(rs0_err), 64'd1);
        chk("misal_rdata", rs0_rdata, 64'd0);
        chk("misal_wen",   64'(tmr_wen), 64'd0);
        cyc();
        issue(0, 64'h0300_0000, 1'b1, 64'hFFFF, 8'hFF);
        chk("unmap_rsp",  64'(rs0_valid), 64'd1);
        chk("unmap_err",  64'(rs0_err), 64'd1);
        chk("unmap_wen",  64'(tmr_wen), 64'd0);
        chk("unmap_addr", tmr_addr, 64'd0);
        cyc();
        issue(0, A_CMP, 1'b1, 64'h5555, 8'h00);
        chk("strb0_rsp", 64'(rs0_valid), 64'd1);
        chk("strb0_err", 64'(rs0_err), 64'd0);
        cyc();
        chk("err_no_wen", 64'(wen_cnt), 64'(wen_base));
        chk("err_cmp_kept", m_cmp, 64'h1111_22AB);

        // Response back-pressure on port 0 while port 1 waits
        rs0_ready = 1'b0;
        issue(0, A_CMP, 1'b0, 64'h0, 8'h00);
        r1_addr = A_MT; r1_wen = 1'b0; r1_wstrb = 8'h00; r1_valid = 1'b1;
        #1;
        chk("bp_req1_rd", 64'(r1_ready), 64'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp0_valid", 64'(rs0_valid), 64'd1);
            chk("bp_rsp0_rdata", rs0_rdata, 64'h1111_22AB);
            chk("bp_req1_ready", 64'(r1_ready), 64'd0);
            chk("bp_rsp1_valid", 64'(rs1_valid), 64'd0);
            cyc();
        end
        rs0_ready = 1'b1;
        #1;
        chk("bp_rsp0_held", 64'(rs0_valid), 64'd1);
        cyc();
        chk("bp_req1_grant", 64'(r1_ready), 64'd1);
        chk("bp_rsp0_done",  64'(rs0_valid), 64'd0);
        cyc();
        r1_valid = 1'b0;
        cyc();
        chk("bp_rsp1_valid", 64'(rs1_valid), 64'd1);
        chk("bp_rsp1_rdata", rs1_rdata, MT_INIT);
        cyc();

        // Reset while a partial write sits in its read cycle
        issue(0, A_CMP, 1'b1, 64'hCAFE_0000_0000_0000, 8'hF0);
        chk("rstmid_rd_addr", tmr_addr, A_CMP);
        wen_base = wen_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_wen",   64'(tmr_wen), 64'd0);
        chk("rstmid_addr",  tmr_addr, 64'd0);
        chk("rstmid_rsp0",  64'(rs0_valid), 64'd0);
        repeat (2) cyc();
        chk("rstmid_wen_hold", 64'(tmr_wen), 64'd0);
        chk("rstmid_no_wen",   64'(wen_cnt), 64'(wen_base));
        chk("rstmid_cmp_kept", m_cmp, 64'h1111_22AB);
        #2 rst_n = 1'b1;
        cyc();
        issue(0, A_CMP, 1'b0, 64'h0, 8'h00);
        cyc();
        chk("post_rst_rsp",   64'(rs0_valid), 64'd1);
        chk("post_rst_rdata", rs0_rdata, 64'h1111_22AB);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint_bus_ctrl.md
Name: clint_bus_ctrl

Overview:
- Front-end controller for the CLINT timer register block (mtime/mtimecmp).
- Arbitrates two requesters onto the timer's single register port: port 0 is the MEM-stage load/store path, port 1 is the debug/host path.
- Decodes and aligns each access, and performs read-modify-write for partial (byte-strobed) stores.
- Sits between MEM/debug and the timer; the timer keeps its own counting and compare logic.

Parameters:
- ADDR_MTIME, 64'h200_BFF8, byte address of mtime.
- ADDR_MTIMECMP, 64'h200_4000, byte address of mtimecmp.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low.
- i_req0_valid / o_req0_ready  in/out  1  port-0 request handshake.
- i_req0_addr  in  64  port-0 byte address.
- i_req0_wen  in  1  port-0 write (1) / read (0).
- i_req0_wdata  in  64  port-0 write data.
- i_req0_wstrb  in  8  port-0 byte enables (writes only).
- o_rsp0_valid / i_rsp0_ready  out/in  1  port-0 response handshake.
- o_rsp0_rdata  out  64  port-0 read data.
- o_rsp0_err  out  1  port-0 decode error.
- i_req1_* / o_req1_ready / o_rsp1_* / i_rsp1_ready  same widths, same meaning, port 1.
- o_tmr_wen  out  1  timer write enable.
- o_tmr_addr  out  64  timer address.
- o_tmr_wdata  out  64  timer write data.
- i_tmr_rdata  in  64  timer read data; combinational from o_tmr_addr.

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - all o_rsp*_valid/err/rdata = 0.
  - o_tmr_wen = 0; o_tmr_addr/wdata = 0.
  - FSM = IDLE; rr_last = 1, so port 0 wins the first tie.
- States: IDLE, RD, WR, RSP.
- IDLE:
  - o_reqN_ready = 1 for the selected port only. Selection is round-robin: on a tie, grant the port not equal to rr_last.
  - On accept (cycle T), latch addr/wen/wdata/wstrb/port and set rr_last = port.
- Decode error: addr not equal to ADDR_MTIME or ADDR_MTIMECMP, or addr[2:0] != 0.
  - Go directly to RSP with err=1, rdata=0.
  - No timer access at all; o_tmr_wen stays 0.
- Read: IDLE -> RD. In RD (T+1), drive o_tmr_addr and capture i_tmr_rdata. RD -> RSP; rsp_valid at T+2.
- Full write (wstrb == 8'hFF): IDLE -> WR. In WR (T+1), o_tmr_wen = 1 for exactly one cycle with addr/wdata. WR -> RSP; rsp_valid at T+2.
- Partial write (wstrb != 8'hFF, != 0): IDLE -> RD -> WR.
  - In RD (T+1), read the current value.
  - In WR (T+2), write merged = (rdata & ~mask) | (wdata & mask), where mask expands wstrb bytewise.
  - rsp_valid at T+3.
  - mtime counting between the read and write cycles is lost; this is accepted behaviour.
- wstrb == 0 write: no timer access; RSP with err=0.
- RSP:
  - rsp_valid held with stable rdata/err until rsp_ready; response goes to the originating port only.
  - Handshake completes -> IDLE.
  - No new request is accepted until then; ready = 0 outside IDLE.
- o_tmr_wen is 1 only in the WR state; o_tmr_addr is driven only in RD/WR, otherwise 0. The timer reloads on any wen, so spurious wen is forbidden.
- Reset mid-operation: immediately IDLE; any pending write is dropped (no wen); the response is discarded.
- A requester holding valid while not granted must keep addr/data stable (requester obligation); the controller never drops a request.

Decomposition:
- clint_pkg:
  - ADDR_MTIME, ADDR_MTIMECMP constants.
  - state typedef {IDLE, RD, WR, RSP}.
  - strb_to_mask function.
- One sub-module, clint_rr_arb2: 2-way round-robin grant with rr_last register, updated on accept.
- Datapath and FSM stay in clint_bus_ctrl.

Test Plan:
- Port0 full write, addr=0x200_4000, wdata=0x1234, strb=FF -> wen=1 at T+1 with wdata 0x1234; rsp0_valid at T+2, err=0; subsequent read of 0x200_4000 returns 0x1234.
- Port1 partial write strb=8'h01, wdata=0xAB, timer mtimecmp=0x1111_2222 -> read at T+1, write 0x1111_22AB at T+2, rsp1 at T+3.
- Both ports valid continuously, reads -> grants alternate 0,1,0,1; no starvation over 8 requests; each response returns on the correct port.
- Addr 0x200_4004, then addr 0x300_0000 -> rsp err=1 at T+1 each; o_tmr_wen never asserted.
- rsp_ready held low 5 cycles -> rsp_valid/rdata stable; other port's ready stays 0; after release, other port is accepted next cycle.
- rst_n asserted during WR-pending partial write (RD state) -> no wen pulse; outputs return to reset values asynchronously; ready reasserts after deassertion.
